accum_dump: RTL and testbench
=============================

Name: accum_dump

Overview:
- Parametrised integrate-and-dump accumulator; successor to the 4-bit single-bit accumulator.
- Accepts IN_W-bit unsigned samples over a valid/ready handshake and adds or subtracts each sample into an ACC_W-bit register.
- After every DUMP_N accepted samples it presents the block total on a held valid/ready output port, flags overflow, and restarts from zero.
- Sits between sample producers (counters, serial front ends) and downstream consumers that read one total per block.

Parameters:
- IN_W, 4, input sample width (unsigned).
- ACC_W, 8, accumulator and dump width; must be >= IN_W.
- DUMP_N, 4, accepted samples per block; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- clr  input  1  synchronous clear of the running block.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  IN_W  sample value.
- in_sub  input  1  per-sample mode: 0 = add, 1 = subtract.
- acc_out  output  ACC_W  running accumulator value.
- cnt_out  output  clog2(DUMP_N+1)  samples accepted in the current block.
- dump_valid  output  1  block total available.
- dump_ready  input  1  consumer takes the total.
- dump_data  output  ACC_W  block total.
- dump_ovf  output  1  overflow occurred in the dumped block.

Behaviour:
- Reset, asynchronous, takes effect immediately without a clock edge:
  - acc_out, cnt_out, dump_data, dump_ovf, dump_valid and the internal block overflow flag all go to 0.
  - Reset mid-block or while a dump is pending discards everything.
- Accept: a sample is accepted when in_valid && in_ready.
  - in_ready = !clr && !(dump_valid && cnt == DUMP_N-1).
  - in_ready is combinational from clr and registered state only, never from dump_ready.
  - dump_valid is not a stall condition except when the next accept would produce a new dump.
- Arithmetic:
  - in_data is zero-extended to ACC_W+1 bits.
  - next = acc ± in_data, result truncated to ACC_W bits, so it wraps modulo 2^ACC_W.
  - Overflow: carry out on add, or borrow on subtract. It sets the internal sticky block_ovf.
- Latency:
  - acc_out and cnt_out update on the edge after an accept (1 cycle).
  - No change on cycles without an accept.
- Dump, when the accept makes cnt reach DUMP_N:
  - dump_data <= next result and dump_ovf <= block_ovf | this sample's overflow.
  - dump_valid <= 1.
  - acc <= 0, cnt <= 0 and block_ovf <= 0, all on the same edge.
  - dump_valid asserts 1 cycle after the DUMP_N-th accept.
- Dump handshake:
  - dump_data and dump_ovf are held stable while dump_valid && !dump_ready.
  - dump_valid clears on the edge where dump_valid && dump_ready, unless a new dump is produced on that same edge. In that case dump_valid stays 1 and the new data loads.
  - A dump is never lost or overwritten before acceptance; this is guaranteed by in_ready.
- clr, synchronous:
  - acc, cnt and block_ovf go to 0.
  - It has priority over a same-cycle sample; in_ready is 0, so the sample is not accepted.
  - A pending dump (dump_valid, dump_data, dump_ovf) is unaffected, and dump_ready is still honoured.
- DUMP_N = 1: every accept dumps; acc_out stays 0. in_ready is 0 whenever dump_valid is 1.
- State: cnt 0..DUMP_N-1 forms the block state; dump_valid forms the output-pending state. No other FSM state.

Optional Feature:
- Macro: ACCUM_DUMP_SAT_EN.
- When defined, arithmetic saturates instead of wrapping:
  - Add overflow clamps to 2^ACC_W-1.
  - Subtract borrow clamps to 0.
  - The overflow flag is still set on each clamp.
- When undefined, arithmetic wraps modulo 2^ACC_W as specified above.
- Handshake, latency and dump behaviour are identical in both builds.

Test Plan:
- Defaults throughout: IN_W=4, ACC_W=8, DUMP_N=4.
- Basic block: dump_ready=1, add 1,2,3,4 back-to-back.
  - acc_out = 1, 3, 6, then 0.
  - dump_valid pulses 1 cycle with dump_data=10, dump_ovf=0.
- Wrap/saturate: from 0, subtract 1 four times.
  - Without the macro: acc_out 255, 254, 253, then dump_data=252, dump_ovf=1.
  - With ACCUM_DUMP_SAT_EN: acc_out stays 0, dump_data=0, dump_ovf=1.
- Backpressure: dump_ready=0 and continuous in_valid with data 1.
  - First dump holds dump_data=4.
  - Three more samples are accepted (cnt_out=3), then in_ready=0.
  - Raise dump_ready for one cycle: the old dump is taken, the 4th sample is accepted next, and the new dump_data=4 appears.
- Clear mid-block: add 5, 5 (acc_out=10), then clr=1 with in_valid=1, in_data=7.
  - acc_out=0, cnt_out=0, sample dropped.
  - Then add 1 ×4: dump_data=4.
- Async reset: assert rst between clock edges while dump_valid=1 and acc_out=6.
  - All outputs go to 0 before the next edge.
  - After release, a fresh block 2,2,2,2 dumps 8.

Source files
------------

// File: rtl/accum_dump.sv
// Integrate-and-dump accumulator: sums DUMP_N accepted samples, presents the block total on a held valid/ready port.
// Optional build macro ACCUM_DUMP_SAT_EN makes the arithmetic saturate instead of wrap.
module accum_dump #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned ACC_W  = 8,
    parameter int unsigned DUMP_N = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_W-1:0]                  in_data,
    input  logic                             in_sub,
    output logic [ACC_W-1:0]                 acc_out,
    output logic [$clog2(DUMP_N+1)-1:0]      cnt_out,
    output logic                             dump_valid,
    input  logic                             dump_ready,
    output logic [ACC_W-1:0]                 dump_data,
    output logic                             dump_ovf
);

    localparam int unsigned CNT_W = $clog2(DUMP_N + 1);
    localparam int unsigned SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             block_ovf_q, block_ovf_d;
    logic             dump_valid_q, dump_valid_d;
    logic [ACC_W-1:0] dump_data_q, dump_data_d;
    logic             dump_ovf_q, dump_ovf_d;

    logic             last_c;
    logic             accept_c;
    logic [SUM_W-1:0] sum_c;
    logic [ACC_W-1:0] res_c;
    logic             ovf_c;

    assign last_c   = (cnt_q == CNT_W'(DUMP_N - 1));
    // Stall only when the next accept would overwrite a pending dump.
    assign in_ready = !clr && !(dump_valid_q && last_c);
    assign accept_c = in_valid && in_ready;

    // Carry (add) or borrow (subtract) appears in the extra top bit.
    always_comb begin
        sum_c = '0;
        if (in_sub) begin
            sum_c = SUM_W'(acc_q) - SUM_W'(in_data);
        end else begin
            sum_c = SUM_W'(acc_q) + SUM_W'(in_data);
        end
        ovf_c = sum_c[ACC_W];
`ifdef ACCUM_DUMP_SAT_EN
        if (ovf_c) begin
            res_c = in_sub ? '0 : '1;
        end else begin
            res_c = sum_c[ACC_W-1:0];
        end
`else
        res_c = sum_c[ACC_W-1:0];
`endif
    end

    // Next-state: block accumulation, dump load and dump handshake.
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        block_ovf_d  = block_ovf_q;
        dump_valid_d = dump_valid_q;
        dump_data_d  = dump_data_q;
        dump_ovf_d   = dump_ovf_q;

        if (dump_valid_q && dump_ready) begin
            dump_valid_d = 1'b0;
        end

        if (clr) begin
            acc_d       = '0;
            cnt_d       = '0;
            block_ovf_d = 1'b0;
        end else if (accept_c) begin
            if (last_c) begin
                dump_data_d  = res_c;
                dump_ovf_d   = block_ovf_q | ovf_c;
                dump_valid_d = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
                block_ovf_d  = 1'b0;
            end else begin
                acc_d       = res_c;
                cnt_d       = cnt_q + CNT_W'(1);
                block_ovf_d = block_ovf_q | ovf_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            block_ovf_q  <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            dump_ovf_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            block_ovf_q  <= block_ovf_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            dump_ovf_q   <= dump_ovf_d;
        end
    end

    assign acc_out    = acc_q;
    assign cnt_out    = cnt_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_data_q;
    assign dump_ovf   = dump_ovf_q;

endmodule

// File: tb/tb_accum_dump.sv
// Directed bench for accum_dump at default parameters; honours ACCUM_DUMP_SAT_EN for the wrap/saturate step.
module tb_accum_dump;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_sub;
    logic [7:0] acc_out;
    logic [2:0] cnt_out;
    logic       dump_valid;
    logic       dump_ready;
    logic [7:0] dump_data;
    logic       dump_ovf;

    int tests_run = 0;
    int tests_failed = 0;

    accum_dump #(.IN_W(4), .ACC_W(8), .DUMP_N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sub     (in_sub),
        .acc_out    (acc_out),
        .cnt_out    (cnt_out),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_ovf   (dump_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0; in_sub = 1'b0; dump_ready = 1'b1;
        tick(); tick();
        check("rst_acc", 32'(acc_out), 0);
        check("rst_cnt", 32'(cnt_out), 0);
        check("rst_dv", 32'(dump_valid), 0);
        check("rst_dd", 32'(dump_data), 0);
        check("rst_ovf", 32'(dump_ovf), 0);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 1);

        // Basic block 1,2,3,4
        in_valid = 1'b1;
        in_data = 4'd1; tick(); check("b_acc1", 32'(acc_out), 1); check("b_cnt1", 32'(cnt_out), 1);
        in_data = 4'd2; tick(); check("b_acc2", 32'(acc_out), 3);
        in_data = 4'd3; tick(); check("b_acc3", 32'(acc_out), 6); check("b_dv0", 32'(dump_valid), 0);
        in_data = 4'd4; tick();
        check("b_acc4", 32'(acc_out), 0);
        check("b_cnt4", 32'(cnt_out), 0);
        check("b_dv", 32'(dump_valid), 1);
        check("b_dd", 32'(dump_data), 10);
        check("b_ovf", 32'(dump_ovf), 0);
        in_valid = 1'b0; tick();
        check("b_dv_clr", 32'(dump_valid), 0);

        // Subtract 1 four times from zero
        in_valid = 1'b1; in_sub = 1'b1; in_data = 4'd1;
`ifdef ACCUM_DUMP_SAT_EN
        tick(); check("w_acc1", 32'(acc_out), 0);
        tick(); check("w_acc2", 32'(acc_out), 0);
        tick(); check("w_acc3", 32'(acc_out), 0);
        tick(); check("w_dd", 32'(dump_data), 0);
`else
        tick(); check("w_acc1", 32'(acc_out), 255);
        tick(); check("w_acc2", 32'(acc_out), 254);
        tick(); check("w_acc3", 32'(acc_out), 253);
        tick(); check("w_dd", 32'(dump_data), 252);
`endif
        check("w_ovf", 32'(dump_ovf), 1);
        check("w_dv", 32'(dump_valid), 1);
        in_valid = 1'b0; in_sub = 1'b0; tick();
        check("w_dv_clr", 32'(dump_valid), 0);

        // Backpressure
        dump_ready = 1'b0; in_valid = 1'b1; in_data = 4'd1;
        tick(); tick(); tick(); tick();
        check("p_dv", 32'(dump_valid), 1);
        check("p_dd", 32'(dump_data), 4);
        check("p_ovf", 32'(dump_ovf), 0);
        check("p_ready_open", 32'(in_ready), 1);
        tick(); tick(); tick();
        check("p_cnt3", 32'(cnt_out), 3);
        check("p_acc3", 32'(acc_out), 3);
        check("p_ready_stall", 32'(in_ready), 0);
        tick();
        check("p_cnt_hold", 32'(cnt_out), 3);
        check("p_dd_hold", 32'(dump_data), 4);
        check("p_dv_hold", 32'(dump_valid), 1);
        dump_ready = 1'b1; tick();
        check("p_taken", 32'(dump_valid), 0);
        check("p_ready_after", 32'(in_ready), 1);
        dump_ready = 1'b0; tick();
        check("p_dv2", 32'(dump_valid), 1);
        check("p_dd2", 32'(dump_data), 4);
        check("p_cnt0", 32'(cnt_out), 0);
        dump_ready = 1'b1; in_valid = 1'b0; tick();
        check("p_dv2_clr", 32'(dump_valid), 0);

        // Clear mid-block
        in_valid = 1'b1; in_data = 4'd5;
        tick(); tick();
        check("c_acc10", 32'(acc_out), 10);
        check("c_cnt2", 32'(cnt_out), 2);
        clr = 1'b1; in_data = 4'd7;
        #1;
        check("c_ready0", 32'(in_ready), 0);
        tick();
        check("c_acc0", 32'(acc_out), 0);
        check("c_cnt0", 32'(cnt_out), 0);
        clr = 1'b0; in_data = 4'd1;
        tick(); tick(); tick();
        check("c_dv_early", 32'(dump_valid), 0);
        tick();
        check("c_dv", 32'(dump_valid), 1);
        check("c_dd", 32'(dump_data), 4);
        in_valid = 1'b0; tick();

        // Async reset with a pending dump and acc_out = 6
        dump_ready = 1'b0; in_valid = 1'b1; in_data = 4'd1;
        tick(); tick(); tick(); tick();
        in_data = 4'd1; tick();
        in_data = 4'd2; tick();
        in_data = 4'd3; tick();
        in_valid = 1'b0;
        check("r_acc6", 32'(acc_out), 6);
        check("r_dv1", 32'(dump_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("r_acc", 32'(acc_out), 0);
        check("r_cnt", 32'(cnt_out), 0);
        check("r_dv", 32'(dump_valid), 0);
        check("r_dd", 32'(dump_data), 0);
        #1 rst = 1'b0;
        dump_ready = 1'b1; in_valid = 1'b1; in_data = 4'd2;
        tick(); tick(); tick(); tick();
        check("r_dv_new", 32'(dump_valid), 1);
        check("r_dd_new", 32'(dump_data), 8);
        check("r_ovf_new", 32'(dump_ovf), 0);
        in_valid = 1'b0; tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
